// File: rtl/pipe_reg_mem_wb.sv
// MEM/WB pipeline register for the RV32 core.
//
// Carries the writeback payload (data, rd, write enable, instruction word) and a valid bit
// from MEM to WB. Supports stall (hold), flush (bubble injection) and optional suppression
// of writes to x0. Also keeps a one-entry shadow of the last retired register write for
// WB-to-ID/EX forwarding, and a wrapping retired-instruction counter.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   valid_in, inst_in,    - MEM-stage instruction and writeback payload
//   data_in, rd_in, we_in
//   stall, flush          - hold current contents / replace incoming with a bubble
//   valid_out, inst_out,  - registered WB-stage payload; we_out is the qualified write enable
//   data_out, rd_out, we_out
//   fwd_valid, fwd_rd,    - register/data written by the most recent retired writer
//   fwd_data
//   retired_count         - number of valid instructions that left the stage (wraps)
module pipe_reg_mem_wb #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RADDR_W    = 5,
    parameter int unsigned INST_W     = 32,
    parameter int unsigned CNT_W      = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'h00000013,
    parameter bit          ZERO_GUARD = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [INST_W-1:0]  inst_in,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [RADDR_W-1:0] rd_in,
    input  logic               we_in,
    input  logic               stall,
    input  logic               flush,
    output logic               valid_out,
    output logic [INST_W-1:0]  inst_out,
    output logic [DATA_W-1:0]  data_out,
    output logic [RADDR_W-1:0] rd_out,
    output logic               we_out,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]  fwd_data,
    output logic [CNT_W-1:0]   retired_count
);

    logic               valid_q, valid_d;
    logic [INST_W-1:0]  inst_q, inst_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [RADDR_W-1:0] rd_q, rd_d;
    logic               we_q, we_d;
    logic               fwd_valid_q, fwd_valid_d;
    logic [RADDR_W-1:0] fwd_rd_q, fwd_rd_d;
    logic [DATA_W-1:0]  fwd_data_q, fwd_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic retire;
    logic we_qual;

    always_comb begin
        // The occupant leaves on any edge where it is not held; a flush always evicts it.
        retire  = valid_q & (~stall | flush);
        we_qual = we_in & valid_in & (!ZERO_GUARD || (rd_in != '0));

        valid_d = valid_q;
        inst_d  = inst_q;
        data_d  = data_q;
        rd_d    = rd_q;
        we_d    = we_q;

        if (flush) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
            data_d  = '0;
            rd_d    = '0;
            we_d    = 1'b0;
        end else if (!stall) begin
            valid_d = valid_in;
            inst_d  = inst_in;
            data_d  = data_in;
            rd_d    = rd_in;
            we_d    = we_qual;
        end

        cnt_d       = retire ? cnt_q + CNT_W'(1) : cnt_q;
        fwd_valid_d = fwd_valid_q;
        fwd_rd_d    = fwd_rd_q;
        fwd_data_d  = fwd_data_q;
        if (retire && we_q) begin
            fwd_valid_d = 1'b1;
            fwd_rd_d    = rd_q;
            fwd_data_d  = data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            inst_q      <= NOP_INST;
            data_q      <= '0;
            rd_q        <= '0;
            we_q        <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_rd_q    <= '0;
            fwd_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            inst_q      <= inst_d;
            data_q      <= data_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_rd_q    <= fwd_rd_d;
            fwd_data_q  <= fwd_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign valid_out     = valid_q;
    assign inst_out      = inst_q;
    assign data_out      = data_q;
    assign rd_out        = rd_q;
    assign we_out        = we_q;
    assign fwd_valid     = fwd_valid_q;
    assign fwd_rd        = fwd_rd_q;
    assign fwd_data      = fwd_data_q;
    assign retired_count = cnt_q;

endmodule
